// File: rtl/spi_cs_sequencer.sv
// spi_cs_sequencer: frames multi-byte SPI_Master transfers under one chip-select assertion,
// enforcing CS setup and inactive timing and tagging received bytes with their 1-based index.
// Optional feature macro: SPI_CS_TIMEOUT_EN aborts a transaction left waiting in NEXT
// for TIMEOUT_CLKS cycles (o_Timeout pulses, CS released).
module spi_cs_sequencer #(
    parameter int unsigned MAX_BYTES_PER_CS = 4,
    parameter int unsigned CS_SETUP_CLKS    = 2,
    parameter int unsigned CS_INACTIVE_CLKS = 8,
    parameter int unsigned TIMEOUT_CLKS     = 1024,
    localparam int unsigned CW              = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [CW-1:0] i_TX_Count,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_Timeout,
    output logic [7:0]    o_SPI_TX_Byte,
    output logic          o_SPI_TX_DV,
    input  logic          i_SPI_TX_Ready,
    input  logic          i_SPI_RX_DV,
    input  logic [7:0]    i_SPI_RX_Byte,
    output logic          o_SPI_CS_n
);

    localparam int unsigned TIMING_MAX =
        (CS_SETUP_CLKS > CS_INACTIVE_CLKS) ? CS_SETUP_CLKS : CS_INACTIVE_CLKS;
`ifdef SPI_CS_TIMEOUT_EN
    localparam int unsigned CNT_MAX = (TIMEOUT_CLKS > TIMING_MAX) ? TIMEOUT_CLKS : TIMING_MAX;
`else
    localparam int unsigned CNT_MAX = TIMING_MAX;
`endif
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, BUSY, NEXT, INACTIVE} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   idx_inc;
    logic            rdy_en_q;
    logic            cs_n_d, tx_dv_d, rx_dv_d, timeout_d;
    logic [7:0]      tx_byte_d, rx_byte_d;
    logic [CW-1:0]   rx_count_d;
    logic            count_ok;

    assign idx_inc  = idx_q + CW'(1);
    assign count_ok = (i_TX_Count != '0) && (i_TX_Count <= CW'(MAX_BYTES_PER_CS));

    // Ready is held low from reset until the first clock edge, then follows SPI_Master in IDLE/NEXT
    assign o_TX_Ready = rdy_en_q && i_SPI_TX_Ready && ((state_q == IDLE) || (state_q == NEXT));

    // Next-state and next-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        idx_d      = idx_q;
        cs_n_d     = o_SPI_CS_n;
        tx_byte_d  = o_SPI_TX_Byte;
        tx_dv_d    = 1'b0;
        rx_dv_d    = 1'b0;
        rx_byte_d  = o_RX_Byte;
        rx_count_d = o_RX_Count;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_TX_DV && o_TX_Ready && count_ok) begin
                    count_d   = i_TX_Count;
                    tx_byte_d = i_TX_Byte;
                    cs_n_d    = 1'b0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP_CLKS - 1)) begin
                    tx_dv_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BUSY: begin
                if (i_SPI_RX_DV) begin
                    rx_dv_d    = 1'b1;
                    rx_byte_d  = i_SPI_RX_Byte;
                    rx_count_d = idx_inc;
                    idx_d      = idx_inc;
                    cnt_d      = '0;
                    if (idx_inc < count_q) begin
                        state_d = NEXT;
                    end else begin
                        cs_n_d  = 1'b1;
                        state_d = INACTIVE;
                    end
                end
            end
            NEXT: begin
                if (i_TX_DV && o_TX_Ready) begin
                    tx_byte_d = i_TX_Byte;
                    tx_dv_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
`ifdef SPI_CS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
                    cs_n_d    = 1'b1;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = INACTIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            INACTIVE: begin
                if (cnt_q == CNT_W'(CS_INACTIVE_CLKS - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset releases CS immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            rdy_en_q      <= 1'b0;
            o_SPI_CS_n    <= 1'b1;
            o_SPI_TX_Byte <= '0;
            o_SPI_TX_DV   <= 1'b0;
            o_RX_DV       <= 1'b0;
            o_RX_Byte     <= '0;
            o_RX_Count    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            rdy_en_q      <= 1'b1;
            o_SPI_CS_n    <= cs_n_d;
            o_SPI_TX_Byte <= tx_byte_d;
            o_SPI_TX_DV   <= tx_dv_d;
            o_RX_DV       <= rx_dv_d;
            o_RX_Byte     <= rx_byte_d;
            o_RX_Count    <= rx_count_d;
        end
    end

`ifdef SPI_CS_TIMEOUT_EN
    // Timeout strobe register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_Timeout <= 1'b0;
        else          o_Timeout <= timeout_d;
    end
`else
    assign o_Timeout = 1'b0;
`endif

endmodule

// File: doc/spi_cs_sequencer.md
Name: spi_cs_sequencer

Overview:
Transaction controller placed between a user client and SPI_Master. It owns the chip-select line and frames multi-byte transfers under one CS assertion. It feeds bytes to SPI_Master one at a time over its TX_DV/TX_Ready handshake, forwards received bytes with an index, and enforces CS setup and inactive timing.

Parameters:
MAX_BYTES_PER_CS, 4, maximum bytes per CS assertion; count port width CW = $clog2(MAX_BYTES_PER_CS+1)
CS_SETUP_CLKS, 2, i_clk cycles from CS_n falling to the first SPI_Master TX_DV pulse (minimum 1)
CS_INACTIVE_CLKS, 8, i_clk cycles CS_n stays high after a transaction before the next one may start (minimum 1)
TIMEOUT_CLKS, 1024, idle-byte timeout; used only when SPI_CS_TIMEOUT_EN is defined

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_TX_Count  in  CW  bytes in the transaction; sampled only on the starting i_TX_DV
i_TX_Byte  in  8  byte to send
i_TX_DV  in  1  one-cycle strobe; valid only while o_TX_Ready=1
o_TX_Ready  out  1  sequencer accepts i_TX_DV this cycle
o_RX_DV  out  1  one-cycle strobe; received byte valid
o_RX_Byte  out  8  received byte
o_RX_Count  out  CW  1-based index of o_RX_Byte within the transaction
o_Timeout  out  1  one-cycle strobe on timeout abort
o_SPI_TX_Byte  out  8  to SPI_Master i_TX_Byte
o_SPI_TX_DV  out  1  to SPI_Master i_TX_DV
i_SPI_TX_Ready  in  1  from SPI_Master o_TX_Ready
i_SPI_RX_DV  in  1  from SPI_Master o_RX_DV
i_SPI_RX_Byte  in  8  from SPI_Master o_RX_Byte
o_SPI_CS_n  out  1  active-low chip select to the slave

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE, o_SPI_CS_n=1, o_TX_Ready=0 until first clock edge, all strobes 0, o_RX_Byte=0, o_RX_Count=0, o_SPI_TX_Byte=0, all counters 0. Reset mid-transaction releases CS at once. Bytes already inside SPI_Master are not tracked.
- All outputs are registered except o_TX_Ready, which is decoded from state and i_SPI_TX_Ready.
- IDLE: o_TX_Ready = i_SPI_TX_Ready.
  - i_TX_DV with i_TX_Count in 1..MAX_BYTES_PER_CS: latch count and byte, drive CS_n=0 on the next edge, clear the byte index, go to SETUP.
  - i_TX_Count=0 or i_TX_Count>MAX_BYTES_PER_CS: request ignored; state stays IDLE and CS is unchanged.
- SETUP: count CS_SETUP_CLKS cycles, then pulse o_SPI_TX_DV for 1 cycle with the latched byte and go to BUSY. o_TX_Ready=0.
- BUSY: wait for i_SPI_RX_DV.
  - On i_SPI_RX_DV: next cycle o_RX_DV=1, o_RX_Byte=i_SPI_RX_Byte, o_RX_Count=index+1.
  - If index+1 < count, go to NEXT; otherwise go to INACTIVE and set CS_n=1 on the same edge as o_RX_DV.
  - o_TX_Ready=0.
- NEXT: CS stays low; o_TX_Ready = i_SPI_TX_Ready. i_TX_DV with ready: latch the byte, pulse o_SPI_TX_DV on the next cycle, go to BUSY. i_TX_Count is ignored here.
- INACTIVE: CS_n=1, o_TX_Ready=0 for CS_INACTIVE_CLKS cycles, then IDLE.
- i_TX_DV while o_TX_Ready=0 is dropped silently; no state change.
- A spurious i_SPI_RX_DV in IDLE, SETUP, NEXT or INACTIVE is ignored and does not produce o_RX_DV.
- Latency: IDLE i_TX_DV to CS_n low = 1 cycle; CS_n low to first o_SPI_TX_DV = CS_SETUP_CLKS cycles; i_SPI_RX_DV to o_RX_DV = 1 cycle.
- o_Timeout is always 0 without the macro.

Optional Feature:
SPI_CS_TIMEOUT_EN
- Defined: a counter runs in NEXT and clears on accepted i_TX_DV. When it reaches TIMEOUT_CLKS: CS_n=1, o_Timeout pulses 1 cycle, go to INACTIVE. Remaining bytes are abandoned and no further o_RX_DV is produced.
- Undefined: no counter. NEXT holds CS low indefinitely; o_Timeout tied 0.

Test Plan:
- Bench setup: SPI_Master with SPI_MODE=3, CLKS_PER_HALF_BIT=4; MISO looped to MOSI.
- Single byte: count=1, byte 0xC1 -> CS_n low 1 cycle after DV; o_SPI_TX_DV exactly 2 cycles later; one o_RX_DV with 0xC1, o_RX_Count=1; CS_n high on that edge; o_TX_Ready low 8 cycles.
- Three bytes: count=3, bytes 0xBE,0xEF,0x5A fed on o_TX_Ready -> CS_n low continuously; RX sequence 0xBE/1, 0xEF/2, 0x5A/3; exactly three o_SPI_TX_DV pulses.
- Illegal count: count=0 and count=5 -> no CS activity, no o_SPI_TX_DV, state stays IDLE.
- Dropped strobe: i_TX_DV pulsed during BUSY -> ignored; only the bytes accepted on o_TX_Ready are sent.
- Reset mid-transaction: assert i_rst_n low during the second byte of a 3-byte transfer -> CS_n=1 asynchronously; after release, IDLE with o_TX_Ready=1 once SPI_Master is ready.
- Timeout (macro defined, TIMEOUT_CLKS=16): count=2, withhold the second byte -> o_Timeout pulses 16 cycles into NEXT, CS_n=1, single o_RX_DV only.
